// File: rtl/avalon_pio_poll_master.sv
// Periodically reads a 1-bit PIO input over Avalon-MM, debounces it and
// counts debounced rising edges.
module avalon_pio_poll_master #(
  parameter int POLL_DIV     = 50000,
  parameter int READ_LATENCY = 1,
  parameter int STABLE_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_count,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        level,
  output logic        rise_pulse,
  output logic        sample_valid,
  output logic [15:0] press_count
);

  // state   | meaning
  // IDLE    | waiting for a divider tick
  // REQ     | read command on the bus until accepted
  // WAIT    | counting out the remaining slave read latency
  // CAPTURE | read data valid, sampled on the closing edge
  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPTURE} state_t;

  localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
  localparam logic [3:0] STAB = 4'(STABLE_COUNT);

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       lat_q;
  logic             avm_read_q;
  logic             sample_valid_q;
  logic             rise_q;
  logic             level_q;
  logic             cand_q;
  logic [3:0]       stab_q;
  logic [15:0]      press_cnt_q;

  logic             tick;
  logic             samp;
  logic             cand_d;
  logic [3:0]       stab_d;
  logic             level_d;
  logic             unused_rdata;

  assign tick         = enable && (div_q == DIV_LAST);
  assign samp         = avm_readdata[0];
  assign unused_rdata = ^avm_readdata[31:1];

  always_ff @(posedge clk) begin
    if (reset || !enable || tick) div_q <= '0;
    else                          div_q <= div_q + 1'b1;
  end

  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (samp == cand_q) begin
      if (stab_q < STAB) stab_d = stab_q + 4'd1;
    end else begin
      cand_d = samp;
      stab_d = 4'd1;
    end
    level_d = (stab_d == STAB) ? cand_d : level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      lat_q          <= '0;
      avm_read_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      rise_q         <= 1'b0;
      level_q        <= 1'b0;
      cand_q         <= 1'b0;
      stab_q         <= '0;
    end else begin
      sample_valid_q <= 1'b0;
      rise_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q    <= REQ;
            avm_read_q <= 1'b1;
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            if (READ_LATENCY == 1) begin
              state_q <= CAPTURE;
            end else begin
              state_q <= WAIT;
              lat_q   <= 2'(READ_LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (lat_q == 2'd0) state_q <= CAPTURE;
          else               lat_q   <= lat_q - 2'd1;
        end
        CAPTURE: begin
          state_q        <= IDLE;
          sample_valid_q <= 1'b1;
          cand_q         <= cand_d;
          stab_q         <= stab_d;
          level_q        <= level_d;
          rise_q         <= level_d & ~level_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // a clear coinciding with a rise pulse wins; the press is dropped
  always_ff @(posedge clk) begin
    if (reset || clear_count)                  press_cnt_q <= '0;
    else if (rise_q && press_cnt_q != 16'hFFFF) press_cnt_q <= press_cnt_q + 16'd1;
  end

  assign avm_address  = 2'b00;
  assign avm_read     = avm_read_q;
  assign sample_valid = sample_valid_q;
  assign rise_pulse   = rise_q;
  assign level        = level_q;
  assign press_count  = press_cnt_q;

endmodule

// File: tb/tb_avalon_pio_poll_master.sv
// Bench for avalon_pio_poll_master: DUT a (div 8, latency 1, stable 3) and
// DUT b (div 8, latency 3, stable 1) against a transaction-level model.
module tb_avalon_pio_poll_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        a_reset, a_en, a_clr, a_wr;
  logic [31:0] a_rd;
  logic [1:0]  a_addr;
  logic        a_read, a_level, a_rise, a_sv;
  logic [15:0] a_pc;

  logic        b_reset, b_en, b_clr, b_wr;
  logic [31:0] b_rd;
  logic [1:0]  b_addr;
  logic        b_read, b_level, b_rise, b_sv;
  logic [15:0] b_pc;

  bit samp_a [0:63];
  int b_cyc;
  bit b_level_m;
  logic [15:0] b_pc_m;

  avalon_pio_poll_master #(.POLL_DIV(8), .READ_LATENCY(1), .STABLE_COUNT(3)) u_a (
    .clk(clk), .reset(a_reset), .enable(a_en), .clear_count(a_clr),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wr),
    .avm_readdata(a_rd), .level(a_level), .rise_pulse(a_rise),
    .sample_valid(a_sv), .press_count(a_pc));

  avalon_pio_poll_master #(.POLL_DIV(8), .READ_LATENCY(3), .STABLE_COUNT(1)) u_b (
    .clk(clk), .reset(b_reset), .enable(b_en), .clear_count(b_clr),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_wr),
    .avm_readdata(b_rd), .level(b_level), .rise_pulse(b_rise),
    .sample_valid(b_sv), .press_count(b_pc));

  // Model: a request starts one cycle after a tick seen while idle; the
  // transaction runs REQ..accept, capture at accept+1, sample_valid at accept+2.
  // Level changes once the last 3 samples agree.
  task automatic run_a(input int nreads, input int stall_s, input int stall_len,
                       input int clr_rise, input bit preload);
    int c, in_req, last_cap, pend_sv, pend_k, cur_k, k_req, k_done, nrise, last_sv;
    bit exp_level, exp_rise, exp_sv, exp_read, prev_rise, prev_clr, all_eq, nl;
    logic [15:0] exp_pc;
    logic [31:0] tmp;
    bit hist[$];
    @(negedge clk);
    a_reset = 1'b1; a_en = 1'b1; a_clr = 1'b0; a_wr = 1'b0; a_rd = '0;
    repeat (2) @(negedge clk);
    a_reset = 1'b0;
    c = 0; in_req = 0; last_cap = -10; pend_sv = -1; pend_k = 0; cur_k = 0;
    k_req = 0; k_done = 0; nrise = 0; last_sv = 0;
    exp_level = 0; prev_rise = 0; prev_clr = 0;
    exp_pc = preload ? 16'hFFFE : 16'h0000;
    if (preload) force u_a.press_cnt_q = 16'hFFFE;
    while (1) begin
      @(negedge clk);
      c++;
      if (c == 1 && preload) release u_a.press_cnt_q;
      if (prev_clr) exp_pc = 16'h0000;
      else if (prev_rise && exp_pc != 16'hFFFF) exp_pc = exp_pc + 16'd1;
      exp_rise = 0; exp_sv = 0;
      if (in_req == 0 && c % 8 == 0 && last_cap <= c - 2) begin
        in_req = 1; cur_k = (k_req < 64) ? k_req : 63; k_req++;
        tmp = $urandom();
        a_rd = {tmp[31:1], samp_a[cur_k]};
      end
      a_wr = (c >= stall_s && c < stall_s + stall_len);
      exp_read = (in_req != 0);
      if (in_req != 0 && !a_wr) begin
        last_cap = c + 1; pend_sv = c + 2; pend_k = cur_k;
      end
      if (c == pend_sv) begin
        exp_sv = 1; k_done++; last_sv = c;
        hist.push_back(samp_a[pend_k]);
        if (hist.size() >= 3) begin
          nl = hist[hist.size()-1];
          all_eq = (hist[hist.size()-2] == nl) && (hist[hist.size()-3] == nl);
          if (all_eq) begin
            if (nl && !exp_level) begin exp_rise = 1; nrise++; end
            exp_level = nl;
          end
        end
      end
      checks++;
      if (a_read !== exp_read) begin errors++; $display("FAIL a_read c=%0d got=%b exp=%b", c, a_read, exp_read); end
      checks++;
      if (a_addr !== 2'b00) begin errors++; $display("FAIL a_addr c=%0d got=%0d exp=0", c, a_addr); end
      checks++;
      if (a_sv !== exp_sv) begin errors++; $display("FAIL a_sample_valid c=%0d got=%b exp=%b", c, a_sv, exp_sv); end
      checks++;
      if (a_level !== exp_level) begin errors++; $display("FAIL a_level c=%0d got=%b exp=%b", c, a_level, exp_level); end
      checks++;
      if (a_rise !== exp_rise) begin errors++; $display("FAIL a_rise c=%0d got=%b exp=%b", c, a_rise, exp_rise); end
      checks++;
      if (a_pc !== exp_pc) begin errors++; $display("FAIL a_press_count c=%0d got=%h exp=%h", c, a_pc, exp_pc); end
      a_clr = (exp_rise && nrise == clr_rise);
      prev_clr = a_clr; prev_rise = exp_rise;
      if (in_req != 0 && !a_wr) in_req = 0;
      if (k_done >= nreads && c >= last_sv + 3) break;
      if (c > 1500) begin
        errors++; checks++;
        $display("FAIL a_timeout reads got=%0d exp=%0d", k_done, nreads);
        break;
      end
    end
    a_clr = 1'b0;
    a_wr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    a_rd = $urandom(); b_rd = $urandom();
    @(negedge clk);
    checks++;
    if ({a_read, a_addr, a_sv, a_level, a_rise} !== 5'b0) begin errors++; $display("FAIL reset_a_ctrl got=%b exp=0", {a_read, a_addr, a_sv, a_level, a_rise}); end
    checks++;
    if (a_pc !== 16'h0) begin errors++; $display("FAIL reset_a_pc got=%h exp=0000", a_pc); end
    checks++;
    if ({b_read, b_addr, b_sv, b_level, b_rise, b_pc} !== 21'b0) begin errors++; $display("FAIL reset_b got=%h exp=0", {b_read, b_addr, b_sv, b_level, b_rise, b_pc}); end
  endtask

  task automatic test_constant_ones();
    for (int i = 0; i < 64; i++) samp_a[i] = 1'b1;
    run_a(4, -1, 0, -1, 1'b0);
  endtask

  task automatic test_sequence();
    bit [4:0] s;
    s = 5'b11101;
    for (int i = 0; i < 64; i++) samp_a[i] = 1'b0;
    for (int i = 0; i < 5; i++) samp_a[i] = s[i];
    run_a(5, -1, 0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++) samp_a[i] = 1'($urandom_range(0, 1));
    run_a(30, -1, 0, 2, 1'b0);
  endtask

  task automatic test_waitrequest();
    for (int i = 0; i < 64; i++) samp_a[i] = 1'($urandom_range(0, 1));
    run_a(3, 8, 8, -1, 1'b0);
    run_a(3, 8, 5, -1, 1'b0);
  endtask

  task automatic test_saturation();
    bit [14:0] s;
    s = 15'b111000111000111;
    for (int i = 0; i < 64; i++) samp_a[i] = 1'b0;
    for (int i = 0; i < 15; i++) samp_a[i] = s[i];
    run_a(15, -1, 0, 3, 1'b1);
  endtask

  // DUT b: accept at A, only readdata in cycle A+3 matters, sample_valid at A+4.
  task automatic test_latency();
    int p;
    bit v, exp_read, exp_sv, exp_rise, prev_rise;
    logic [31:0] tmp;
    @(negedge clk);
    b_reset = 1'b1; b_en = 1'b1; b_clr = 1'b0; b_wr = 1'b0;
    repeat (2) @(negedge clk);
    b_reset = 1'b0;
    b_level_m = 0; b_pc_m = 16'h0; prev_rise = 0; v = 0;
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      b_cyc = c;
      if (prev_rise && b_pc_m != 16'hFFFF) b_pc_m = b_pc_m + 16'd1;
      exp_rise = 0;
      p = (c >= 8) ? (c - 8) % 8 : -1;
      if (p == 0) v = (c == 48) ? 1'b1 : 1'($urandom_range(0, 1));
      tmp = $urandom();
      if (p == 3)                b_rd = {tmp[31:1], v};
      else if (p > 0)            b_rd = {tmp[31:1], ~v};
      else                       b_rd = tmp;
      exp_read = (p == 0);
      exp_sv = (p == 4 && c >= 12);
      if (exp_sv) begin
        if (v && !b_level_m) exp_rise = 1;
        b_level_m = v;
      end
      checks++;
      if (b_read !== exp_read) begin errors++; $display("FAIL b_read c=%0d got=%b exp=%b", c, b_read, exp_read); end
      checks++;
      if (b_sv !== exp_sv) begin errors++; $display("FAIL b_sample_valid c=%0d got=%b exp=%b", c, b_sv, exp_sv); end
      checks++;
      if (b_level !== b_level_m) begin errors++; $display("FAIL b_level c=%0d got=%b exp=%b", c, b_level, b_level_m); end
      checks++;
      if (b_rise !== exp_rise) begin errors++; $display("FAIL b_rise c=%0d got=%b exp=%b", c, b_rise, exp_rise); end
      checks++;
      if (b_pc !== b_pc_m) begin errors++; $display("FAIL b_press_count c=%0d got=%h exp=%h", c, b_pc, b_pc_m); end
      prev_rise = exp_rise;
    end
  endtask

  // Continues from test_latency: read issued at cycle 56 is in WAIT at 57.
  task automatic test_reset_in_wait();
    @(negedge clk);
    b_cyc++;
    checks++;
    if (b_read !== 1'b0 || b_level !== 1'b1) begin errors++; $display("FAIL b_wait_state c=%0d read=%b level=%b exp read=0 level=1", b_cyc, b_read, b_level); end
    b_reset = 1'b1;
    b_rd = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if ({b_read, b_addr, b_sv, b_level, b_rise, b_pc} !== 21'b0) begin errors++; $display("FAIL b_reset_in_wait got=%h exp=0", {b_read, b_addr, b_sv, b_level, b_rise, b_pc}); end
    b_reset = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      checks++;
      if (b_read !== (c == 8)) begin errors++; $display("FAIL b_resume_read c=%0d got=%b exp=%b", c, b_read, (c == 8)); end
      checks++;
      if (b_sv !== 1'b0 || b_level !== 1'b0) begin errors++; $display("FAIL b_late_data c=%0d sv=%b level=%b exp 0 0", c, b_sv, b_level); end
    end
  endtask

  task automatic test_enable_drop();
    bit exp_read, exp_sv;
    @(negedge clk);
    b_reset = 1'b1; b_en = 1'b1; b_wr = 1'b0;
    repeat (2) @(negedge clk);
    b_reset = 1'b0;
    for (int c = 1; c <= 49; c++) begin
      @(negedge clk);
      b_wr = (c == 8 || c == 9);
      if (c == 9) b_en = 1'b0;
      if (c == 41) b_en = 1'b1;
      b_rd = $urandom();
      exp_read = (c >= 8 && c <= 10) || (c == 41 + 8);
      exp_sv = (c == 14);
      checks++;
      if (b_read !== exp_read) begin errors++; $display("FAIL b_en_read c=%0d got=%b exp=%b", c, b_read, exp_read); end
      checks++;
      if (b_sv !== exp_sv) begin errors++; $display("FAIL b_en_sample_valid c=%0d got=%b exp=%b", c, b_sv, exp_sv); end
    end
    b_wr = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_en = 1'b0; a_clr = 1'b0; a_wr = 1'b0; a_rd = '0;
    b_reset = 1'b1; b_en = 1'b0; b_clr = 1'b0; b_wr = 1'b0; b_rd = '0;
    b_cyc = 0;
    test_reset();
    test_constant_ones();
    test_sequence();
    test_random();
    test_waitrequest();
    test_saturation();
    test_latency();
    test_reset_in_wait();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
